// File: rtl/fetch_unit.sv
// Instruction-fetch stage: program counter, IDLE/RUN/DONE sequencing, absolute-branch
// target LUT and a saturating RUN-cycle counter feeding the instruction ROM.
module fetch_unit #(
  parameter int PC_W      = 10,
  parameter int LUT_DEPTH = 64,
  parameter int CNT_W     = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [PC_W-1:0]  StartAddr,
  input  logic             Branch,
  input  logic             BranchEn,
  input  logic [5:0]       PCTarg,
  input  logic             Ack,
  input  logic             Stall,
  input  logic             LutWrEn,
  input  logic [5:0]       LutWrAddr,
  input  logic [PC_W-1:0]  LutWrData,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             Running,
  output logic             Done,
  output logic [CNT_W-1:0] CycleCnt
);

  // Handshake: Start is a level request accepted on any edge where the state is
  // IDLE or DONE; Done stays high until the next accepted Start or Reset.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             running_q, done_q;
  logic [PC_W-1:0]  lut_q [LUT_DEPTH];

  logic [PC_W-1:0]  lut_rd;
  logic [PC_W-1:0]  rel_off;
  logic             lut_wr;

  assign lut_rd  = lut_q[PCTarg];
  assign rel_off = {{(PC_W-6){PCTarg[5]}}, PCTarg};
  assign lut_wr  = LutWrEn && (state_q != RUN);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          state_d = RUN;
          pc_d    = StartAddr;
          cnt_d   = '0;
        end
      end
      RUN: begin
        // Every RUN cycle counts, including stalls and the halt cycle.
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
        if (Stall) begin
          pc_d = pc_q;
        end else if (Ack) begin
          state_d = DONE;
        end else if (Branch) begin
          pc_d = lut_rd;
        end else if (BranchEn) begin
          pc_d = pc_q + rel_off;
        end else begin
          pc_d = pc_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      cnt_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      for (int i = 0; i < LUT_DEPTH; i++) lut_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      running_q <= (state_d == RUN);
      done_q    <= (state_d == DONE);
      if (lut_wr) lut_q[LutWrAddr] <= LutWrData;
    end
  end

  assign ProgCtr  = pc_q;
  assign Running  = running_q;
  assign Done     = done_q;
  assign CycleCnt = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: scenario tasks with a PC scoreboard queue.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, start, branch, branch_en, ack, stall, lut_we;
  logic [9:0]  start_addr, lut_wd;
  logic [5:0]  pc_targ, lut_wa;
  logic [9:0]  prog_ctr;
  logic        running, done;
  logic [15:0] cycle_cnt;

  logic [9:0]  exp_q[$];
  logic [9:0]  exp;
  int          checks = 0;
  int          failures = 0;

  fetch_unit #(.PC_W(10), .LUT_DEPTH(64), .CNT_W(16)) dut (
    .Clk(clk), .Reset(reset), .Start(start), .StartAddr(start_addr),
    .Branch(branch), .BranchEn(branch_en), .PCTarg(pc_targ), .Ack(ack),
    .Stall(stall), .LutWrEn(lut_we), .LutWrAddr(lut_wa), .LutWrData(lut_wd),
    .ProgCtr(prog_ctr), .Running(running), .Done(done), .CycleCnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start = 0; start_addr = '0; branch = 0; branch_en = 0; pc_targ = '0;
    ack = 0; stall = 0; lut_we = 0; lut_wa = '0; lut_wd = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1; step(); reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 4;
    if (prog_ctr !== 10'h000) begin failures++; $display("FAIL reset_pc got=%h exp=000", prog_ctr); end
    if (running !== 1'b0) begin failures++; $display("FAIL reset_running got=%b exp=0", running); end
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    if (cycle_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", cycle_cnt); end
  endtask

  task automatic test_sequential();
    logic [9:0] mdl;
    // IDLE ignores branches/ack/stall
    branch = 1; ack = 1; stall = 1; step(); clear_inputs();
    checks += 2;
    if (prog_ctr !== 10'h000) begin failures++; $display("FAIL idle_hold_pc got=%h exp=000", prog_ctr); end
    if (running !== 1'b0) begin failures++; $display("FAIL idle_stays got=%b exp=0", running); end
    start = 1; start_addr = 10'h010; exp_q.push_back(10'h010); step(); clear_inputs();
    mdl = 10'h010;
    for (int i = 0; i < 5; i++) begin
      mdl = mdl + 1'b1;
      exp_q.push_back(mdl);
    end
    exp = exp_q.pop_front();
    checks += 3;
    if (prog_ctr !== exp) begin failures++; $display("FAIL start_pc got=%h exp=%h", prog_ctr, exp); end
    if (running !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL start_state run=%b done=%b exp=1/0", running, done); end
    if (cycle_cnt !== 16'd0) begin failures++; $display("FAIL start_cnt got=%0d exp=0", cycle_cnt); end
    for (int i = 0; i < 5; i++) begin
      step();
      exp = exp_q.pop_front();
      checks++;
      if (prog_ctr !== exp) begin failures++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, prog_ctr, exp); end
    end
    checks++;
    if (cycle_cnt !== 16'd5) begin failures++; $display("FAIL seq_cnt got=%0d exp=5", cycle_cnt); end
  endtask

  task automatic test_lut_branch();
    do_reset();
    lut_we = 1; lut_wa = 6'd3; lut_wd = 10'h2A0; step();
    lut_wa = 6'd0; lut_wd = 10'h050; step(); clear_inputs();
    start = 1; start_addr = 10'h020; step(); clear_inputs();
    branch = 1; pc_targ = 6'd3; exp_q.push_back(10'h2A0); step(); clear_inputs();
    exp = exp_q.pop_front(); checks++;
    if (prog_ctr !== exp) begin failures++; $display("FAIL abs_branch got=%h exp=%h", prog_ctr, exp); end
    // write during RUN must be dropped
    lut_we = 1; lut_wa = 6'd3; lut_wd = 10'h111; exp_q.push_back(10'h2A1); step(); clear_inputs();
    exp = exp_q.pop_front(); checks++;
    if (prog_ctr !== exp) begin failures++; $display("FAIL run_write_seq got=%h exp=%h", prog_ctr, exp); end
    branch = 1; pc_targ = 6'd3; exp_q.push_back(10'h2A0); step(); clear_inputs();
    exp = exp_q.pop_front(); checks++;
    if (prog_ctr !== exp) begin failures++; $display("FAIL run_write_dropped got=%h exp=%h", prog_ctr, exp); end
    branch = 1; branch_en = 1; pc_targ = 6'd0; exp_q.push_back(10'h050); step(); clear_inputs();
    exp = exp_q.pop_front(); checks++;
    if (prog_ctr !== exp) begin failures++; $display("FAIL branch_priority got=%h exp=%h", prog_ctr, exp); end
    start = 1; start_addr = 10'h200; exp_q.push_back(10'h051); step(); clear_inputs();
    exp = exp_q.pop_front(); checks += 2;
    if (prog_ctr !== exp) begin failures++; $display("FAIL start_in_run got=%h exp=%h", prog_ctr, exp); end
    if (cycle_cnt !== 16'd5) begin failures++; $display("FAIL run_cnt got=%0d exp=5", cycle_cnt); end
  endtask

  task automatic test_rel_branch();
    logic [9:0] starts [3] = '{10'h005, 10'h3FF, 10'h3FF};
    logic       rel    [3] = '{1'b1, 1'b1, 1'b0};
    logic [5:0] targs  [3] = '{6'b111100, 6'd2, 6'd0};
    logic [9:0] exps   [3] = '{10'h001, 10'h001, 10'h000};
    for (int i = 0; i < 3; i++) begin
      ack = 1; step(); clear_inputs();
      start = 1; start_addr = starts[i]; step(); clear_inputs();
      branch_en = rel[i]; pc_targ = targs[i]; exp_q.push_back(exps[i]); step(); clear_inputs();
      exp = exp_q.pop_front(); checks++;
      if (prog_ctr !== exp) begin failures++; $display("FAIL rel_branch[%0d] got=%h exp=%h", i, prog_ctr, exp); end
    end
  endtask

  task automatic test_stall_ack();
    logic [9:0]  pc0;
    logic [15:0] cnt0;
    pc0 = prog_ctr; cnt0 = cycle_cnt;
    stall = 1; ack = 1; branch = 1; step(); step(); clear_inputs();
    checks += 3;
    if (prog_ctr !== pc0) begin failures++; $display("FAIL stall_pc got=%h exp=%h", prog_ctr, pc0); end
    if (running !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL stall_state run=%b done=%b exp=1/0", running, done); end
    if (cycle_cnt !== cnt0 + 16'd2) begin failures++; $display("FAIL stall_cnt got=%0d exp=%0d", cycle_cnt, cnt0 + 16'd2); end
    ack = 1; step(); clear_inputs();
    checks += 3;
    if (done !== 1'b1 || running !== 1'b0) begin failures++; $display("FAIL ack_state run=%b done=%b exp=0/1", running, done); end
    if (prog_ctr !== pc0) begin failures++; $display("FAIL ack_pc got=%h exp=%h", prog_ctr, pc0); end
    if (cycle_cnt !== cnt0 + 16'd3) begin failures++; $display("FAIL ack_cnt got=%0d exp=%0d", cycle_cnt, cnt0 + 16'd3); end
    branch_en = 1; pc_targ = 6'd4; step(); step(); clear_inputs();
    checks += 2;
    if (prog_ctr !== pc0) begin failures++; $display("FAIL done_pc got=%h exp=%h", prog_ctr, pc0); end
    if (cycle_cnt !== cnt0 + 16'd3) begin failures++; $display("FAIL done_cnt got=%0d exp=%0d", cycle_cnt, cnt0 + 16'd3); end
  endtask

  task automatic test_done_restart();
    // LUT write and Start together: the first branch sees the new entry
    start = 1; start_addr = 10'h100; lut_we = 1; lut_wa = 6'd5; lut_wd = 10'h155;
    step(); clear_inputs();
    checks += 3;
    if (done !== 1'b0 || running !== 1'b1) begin failures++; $display("FAIL restart_state run=%b done=%b exp=1/0", running, done); end
    if (prog_ctr !== 10'h100) begin failures++; $display("FAIL restart_pc got=%h exp=100", prog_ctr); end
    if (cycle_cnt !== 16'd0) begin failures++; $display("FAIL restart_cnt got=%0d exp=0", cycle_cnt); end
    branch = 1; pc_targ = 6'd5; exp_q.push_back(10'h155); step(); clear_inputs();
    exp = exp_q.pop_front(); checks++;
    if (prog_ctr !== exp) begin failures++; $display("FAIL write_with_start got=%h exp=%h", prog_ctr, exp); end
  endtask

  task automatic test_reset_mid_run();
    branch = 1; pc_targ = 6'd5; reset = 1; step(); reset = 0; clear_inputs();
    checks += 4;
    if (prog_ctr !== 10'h000) begin failures++; $display("FAIL midrst_pc got=%h exp=000", prog_ctr); end
    if (running !== 1'b0) begin failures++; $display("FAIL midrst_running got=%b exp=0", running); end
    if (done !== 1'b0) begin failures++; $display("FAIL midrst_done got=%b exp=0", done); end
    if (cycle_cnt !== 16'd0) begin failures++; $display("FAIL midrst_cnt got=%0d exp=0", cycle_cnt); end
    start = 1; start_addr = 10'h030; step(); clear_inputs();
    for (int i = 0; i < 3; i++) begin
      automatic logic [5:0] t = (i == 0) ? 6'd3 : (i == 1) ? 6'd5 : 6'($urandom_range(6, 63));
      branch = 1; pc_targ = t; exp_q.push_back(10'h000); step(); clear_inputs();
      exp = exp_q.pop_front(); checks++;
      if (prog_ctr !== exp) begin failures++; $display("FAIL lut_cleared[%0d] got=%h exp=%h", t, prog_ctr, exp); end
    end
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    test_reset();
    test_sequential();
    test_lut_branch();
    test_rel_branch();
    test_stall_ack();
    test_done_restart();
    test_reset_mid_run();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the control decoder.
- Holds the program counter that addresses the 9-bit instruction ROM.
- Consumes the decoder's Branch, BranchEn, PCTarg and Ack outputs to pick the next PC.
- Sequences program start/finish with a Start/Done handshake to the testbench/top level, and keeps a 64-entry absolute-branch target LUT plus a cycle counter.

Parameters:
- PC_W, 10, program counter width (1024-entry instruction ROM)
- LUT_DEPTH, 64, branch target LUT entries (indexed by the 6-bit PCTarg)
- CNT_W, 16, cycle counter width

Ports:
- Clk  input  1  system clock, all state updates on rising edge
- Reset  input  1  synchronous, active-high reset
- Start  input  1  request to begin executing a program
- StartAddr  input  PC_W  first PC of the program, sampled when Start is accepted
- Branch  input  1  absolute branch from decoder
- BranchEn  input  1  relative branch from decoder
- PCTarg  input  6  LUT index (absolute) or signed offset (relative)
- Ack  input  1  halt instruction decoded
- Stall  input  1  freeze fetch this cycle
- LutWrEn  input  1  LUT write strobe
- LutWrAddr  input  6  LUT write index
- LutWrData  input  PC_W  LUT write data
- ProgCtr  output  PC_W  current instruction address to instruction ROM
- Running  output  1  high while in RUN
- Done  output  1  high while in DONE
- CycleCnt  output  CNT_W  cycles spent in RUN for current/last program

Behaviour:
- Clock and reset: single clock Clk; reset is synchronous and active-high on Reset.
- Reset values: state IDLE, ProgCtr=0, Running=0, Done=0, CycleCnt=0, all LUT entries=0.
- Reset asserted mid-RUN takes effect at the next edge and discards any in-flight branch.
- States: IDLE, RUN, DONE. All outputs are registered or decoded from state only.
- IDLE:
  - ProgCtr holds.
  - Start=1 -> next edge: state RUN, ProgCtr=StartAddr, CycleCnt=0.
  - Ack, Branch, BranchEn and Stall are ignored.
- RUN: next-PC priority, evaluated each cycle:
  1. Stall=1: ProgCtr holds; all other inputs ignored.
  2. Ack=1: state DONE; ProgCtr holds (remains on the halt instruction).
  3. Branch=1: ProgCtr = LUT[PCTarg]. Branch wins if BranchEn is also high.
  4. BranchEn=1: ProgCtr = ProgCtr + sign-extend(PCTarg), range -32..+31, modulo 2^PC_W.
  5. Otherwise: ProgCtr = ProgCtr + 1, wrapping from 2^PC_W-1 to 0.
- RUN, other rules:
  - Start is ignored.
  - CycleCnt increments on every RUN cycle, including stalls and the Ack cycle; it saturates at 2^CNT_W-1.
- DONE:
  - Done=1; ProgCtr and CycleCnt frozen.
  - Start=1 -> next edge: RUN, ProgCtr=StartAddr, CycleCnt=0, Done=0.
- Running = (state==RUN); Done = (state==DONE). They are never high together.
- LUT:
  - Write occurs at the edge when LutWrEn=1 and state is IDLE or DONE.
  - Writes in RUN are dropped.
  - Write and Start in the same cycle: the write completes; the first branch can use the new value.
  - Read is combinational from the current PCTarg.
- Latency: one-cycle redirect. The instruction at the new PC is presented the cycle after a branch is decoded; there are no delay slots.

Test Plan:
- Reset, then Start=1 with StartAddr=0x010, no branches, 5 cycles -> ProgCtr 0x010, 0x011, ..., 0x015; Running=1; CycleCnt=5.
- In IDLE write LUT[3]=0x2A0; in RUN drive Branch=1, PCTarg=3 -> ProgCtr=0x2A0 next cycle. Write LUT[3]=0x111 during RUN -> LUT[3] still 0x2A0.
- ProgCtr=0x005 with BranchEn=1, PCTarg=6'b111100 (-4) -> 0x001. ProgCtr=0x3FF with BranchEn=1, PCTarg=2 -> 0x001 (wrap).
- Stall=1 together with Ack=1 for 2 cycles -> ProgCtr unchanged, state stays RUN, CycleCnt +2. Stall=0, Ack=1 -> Done=1, Running=0 next cycle, ProgCtr frozen.
- In DONE, Start=1, StartAddr=0x100 -> Done=0, ProgCtr=0x100, CycleCnt=0 next cycle. Reset asserted mid-RUN -> all outputs 0 and LUT cleared next edge.
- Branch=1 and BranchEn=1 together (LUT[0]=0x050, PCTarg=0) -> ProgCtr=0x050, the absolute branch wins. Start pulsed during RUN -> ignored.
